script_loader: RTL and testbench
================================

Name: script_loader

Overview:
Writer-side counterpart of the script interpreter. It receives a framed byte stream through a valid/ready handshake and assembles big-endian 16-bit script words {i_num[15:8], i_sign[7:5], func[4:3], op_code[2:0]}. It writes each word into script memory at byte address 2*k, matching the interpreter's pc stride of 2. The frame's length, checksum and op_codes are checked, and completion or error status is reported to the top level.

Parameters:
ADDR_W, 8, script memory byte-address width
HEADER, 8'hA5, frame start byte
MAX_WORDS, 128, largest legal word count (2*MAX_WORDS <= 2^ADDR_W)

Ports:
clk  in  1  system clock
res  in  1  reset, synchronous, active-low
start  in  1  one-cycle load request; ignored unless state is IDLE, DONE or ERROR
rx_valid  in  1  rx_data holds a byte
rx_data  in  8  incoming byte
rx_ready  out  1  loader can accept a byte
mem_we  out  1  script memory write strobe, one cycle per word
mem_addr  out  ADDR_W  byte address of the word being written (always even)
mem_wdata  out  16  script word being written
busy  out  1  a load is in progress
load_done  out  1  sticky; last frame loaded successfully
load_err  out  1  sticky; last frame rejected
err_code  out  2  00 none, 01 bad length, 10 checksum mismatch, 11 illegal op_code
words_loaded  out  8  words written in the current or last frame

Behaviour:
- Reset, sampled on posedge clk with res==0: state IDLE; all outputs 0; the internal index, checksum accumulator and high-byte register are cleared. A reset during a load aborts it at once; words already written stay in memory.
- A byte is accepted only on a cycle with rx_valid && rx_ready. rx_ready is 1 only in WAIT_HDR, GET_LEN, GET_HI, GET_LO and GET_CSUM.
- busy = 1 in every state except IDLE, DONE and ERROR.
- IDLE/DONE/ERROR, start=1: go to WAIT_HDR; clear load_done, load_err, err_code, words_loaded, index and checksum.
- WAIT_HDR: a byte equal to HEADER goes to GET_LEN; any other byte is discarded and the state stays WAIT_HDR.
- GET_LEN: latch N.
  - N==0 or N>MAX_WORDS: go to ERROR with err_code 01.
  - Otherwise go to GET_HI.
- GET_HI: latch the byte as the high byte, XOR it into the checksum, go to GET_LO.
- GET_LO: XOR the byte into the checksum.
  - If byte[2:0] is 0 or 5..7: go to ERROR with err_code 11, and no write occurs. Legal op_codes are 1 action, 2 jump, 3 wait, 4 game.
  - Otherwise go to WRITE.
- WRITE (exactly one cycle, rx_ready=0):
  - mem_we=1, mem_addr = {index, 1'b0} truncated to ADDR_W, mem_wdata = {hi, lo}.
  - index increments and words_loaded = index+1.
  - If index+1 == N go to GET_CSUM, else go to GET_HI.
- GET_CSUM:
  - Received byte == checksum accumulator (XOR of all 2N data bytes; HEADER and N excluded): go to DONE, load_done=1.
  - Otherwise: go to ERROR, load_err=1, err_code 10.
- ERROR sets load_err=1. load_done and load_err hold until the next accepted start or reset.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Latency: the write strobe occurs 1 cycle after the low byte is accepted. Minimum frame time is 3N+3 accepted-byte cycles.
- start while busy is ignored. A rx_valid pulse while rx_ready=0 is not consumed; the source must hold the byte.
- Index wrap cannot occur, because N<=MAX_WORDS is enforced.

Test Plan:
- Nominal frame A5,02,01,21,03,42,csum=01^21^03^42=0x61 -> two writes: addr 0x00 data 0x0121, then addr 0x02 data 0x0342; then load_done=1, words_loaded=2, err_code=00.
- Garbage before header 00,FF,A5,01,10,0C,1C -> 00 and FF discarded; one write, addr 0 data 0x100C; load_done=1.
- Bad checksum A5,01,10,0C,00 -> one write occurs; then load_err=1, err_code=10, load_done=0.
- Length 0 and length 129 (MAX_WORDS=128) -> ERROR with err_code=01 immediately after the length byte; no mem_we.
- Illegal op_code A5,01,05,07 -> no write; ERROR with err_code=11.
- rx_valid held high continuously -> rx_ready=0 in the WRITE cycle and the next byte is taken afterwards.
- res=0 asserted mid-frame after 1 of 3 words -> all outputs 0 next cycle; start, then a full new frame loads from addr 0.

Source files
------------

// File: rtl/script_loader_if.sv
// Byte-stream receive handshake and script-memory write port of the script loader.
// The loader sits on the slave side; the byte source / memory owner sits on the master side.
interface script_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/script_loader.sv
// Receives a framed byte stream (HEADER, N, N big-endian words, XOR checksum) and
// writes each 16-bit script word to script memory at byte address 2*k.
module script_loader #(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] HEADER    = 8'hA5,
   parameter int         MAX_WORDS = 128
) (
   input  logic         clk,
   input  logic         res,
   input  logic         start,
   script_loader_if.slave bus,
   output logic         busy,
   output logic         load_done,
   output logic         load_err,
   output logic [1:0]   err_code,
   output logic [7:0]   words_loaded
);

   typedef enum logic [3:0] {
      IDLE,
      WAIT_HDR,
      GET_LEN,
      GET_HI,
      GET_LO,
      WRITE,
      GET_CSUM,
      DONE,
      ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CSUM = 2'b10;
   localparam logic [1:0] ERR_OP   = 2'b11;
   localparam logic [8:0] MAX_N    = 9'(MAX_WORDS);

   state_t            state_reg, state_next;
   logic [7:0]        len_reg, len_next;
   logic [7:0]        hi_reg, hi_next;
   logic [7:0]        csum_reg, csum_next;
   logic [7:0]        index_reg, index_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [15:0]       wdata_reg, wdata_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   logic [1:0]        code_reg, code_next;
   logic [7:0]        words_reg, words_next;

   logic              rx_ready_c;
   logic              accept;
   logic              op_legal;
   logic [7:0]        index_inc;

   always_ff @(posedge clk) begin
      if (!res) begin
         state_reg <= IDLE;
         len_reg   <= '0;
         hi_reg    <= '0;
         csum_reg  <= '0;
         index_reg <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         code_reg  <= ERR_NONE;
         words_reg <= '0;
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         hi_reg    <= hi_next;
         csum_reg  <= csum_next;
         index_reg <= index_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
         code_reg  <= code_next;
         words_reg <= words_next;
      end
   end

   always_comb begin
      rx_ready_c = 1'b0;
      case (state_reg)
         WAIT_HDR, GET_LEN, GET_HI, GET_LO, GET_CSUM: rx_ready_c = 1'b1;
         default:                                     rx_ready_c = 1'b0;
      endcase
   end

   assign accept    = bus.rx_valid && rx_ready_c;
   assign op_legal  = (bus.rx_data[2:0] >= 3'd1) && (bus.rx_data[2:0] <= 3'd4);
   assign index_inc = index_reg + 8'd1;

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      hi_next    = hi_reg;
      csum_next  = csum_reg;
      index_next = index_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      done_next  = done_reg;
      err_next   = err_reg;
      code_next  = code_reg;
      words_next = words_reg;

      case (state_reg)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_next = WAIT_HDR;
               done_next  = 1'b0;
               err_next   = 1'b0;
               code_next  = ERR_NONE;
               words_next = '0;
               index_next = '0;
               csum_next  = '0;
            end
         end
         WAIT_HDR: begin
            if (accept && bus.rx_data == HEADER) begin
               state_next = GET_LEN;
            end
         end
         GET_LEN: begin
            if (accept) begin
               len_next = bus.rx_data;
               if (bus.rx_data == 8'd0 || {1'b0, bus.rx_data} > MAX_N) begin
                  state_next = ERROR;
                  err_next   = 1'b1;
                  code_next  = ERR_LEN;
               end else begin
                  state_next = GET_HI;
               end
            end
         end
         GET_HI: begin
            if (accept) begin
               hi_next    = bus.rx_data;
               csum_next  = csum_reg ^ bus.rx_data;
               state_next = GET_LO;
            end
         end
         GET_LO: begin
            if (accept) begin
               csum_next = csum_reg ^ bus.rx_data;
               if (!op_legal) begin
                  state_next = ERROR;
                  err_next   = 1'b1;
                  code_next  = ERR_OP;
               end else begin
                  // Address/data are captured here so they are stable during the
                  // WRITE strobe and keep their value afterwards.
                  addr_next  = ADDR_W'({index_reg, 1'b0});
                  wdata_next = {hi_reg, bus.rx_data};
                  words_next = index_inc;
                  state_next = WRITE;
               end
            end
         end
         WRITE: begin
            index_next = index_inc;
            state_next = (index_inc == len_reg) ? GET_CSUM : GET_HI;
         end
         GET_CSUM: begin
            if (accept) begin
               if (bus.rx_data == csum_reg) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  state_next = ERROR;
                  err_next   = 1'b1;
                  code_next  = ERR_CSUM;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.rx_ready  = rx_ready_c;
   assign bus.mem_we    = (state_reg == WRITE);
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_wdata = wdata_reg;

   assign busy         = !(state_reg == IDLE || state_reg == DONE || state_reg == ERROR);
   assign load_done    = done_reg;
   assign load_err     = err_reg;
   assign err_code     = code_reg;
   assign words_loaded = words_reg;

endmodule

// File: tb/tb_script_loader.sv
// Directed frames against a frame-level model of the loader: the model parses each
// frame into expected memory writes and final status; a monitor checks every write.
module tb_script_loader;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       start = 1'b0;
   logic       busy, load_done, load_err;
   logic [1:0] err_code;
   logic [7:0] words_loaded;

   script_loader_if #(.ADDR_W(8)) bus ();

   script_loader #(.ADDR_W(8), .HEADER(8'hA5), .MAX_WORDS(128)) dut (
      .clk          (clk),
      .res          (res),
      .start        (start),
      .bus          (bus),
      .busy         (busy),
      .load_done    (load_done),
      .load_err     (load_err),
      .err_code     (err_code),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          frame_no = 0;
   logic [7:0]  frame[$];
   logic [23:0] exp_q[$];
   logic [15:0] tb_mem[0:127];
   logic        exp_done, exp_err;
   logic [1:0]  exp_code;
   logic [7:0]  exp_words;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Monitor: every write strobe must match the next write the model predicted.
   always @(negedge clk) begin
      if (res && bus.mem_we) begin
         chk("wr_rx_ready_low", bus.rx_ready, 0);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", bus.mem_addr, e[23:16]);
            chk("wr_data", bus.mem_wdata, e[15:0]);
         end
         tb_mem[bus.mem_addr[7:1]] = bus.mem_wdata;
      end
   end

   // Parses the byte list as the frame format defines it; complete=0 if bytes run out.
   task automatic model_frame(output bit complete);
      int         i;
      logic [7:0] n, cs, hi, lo;
      i = 0; cs = 8'h00; complete = 0;
      exp_done = 0; exp_err = 0; exp_code = 2'b00; exp_words = 8'd0;
      while (i < frame.size() && frame[i] != 8'hA5) i++;
      i++;
      if (i >= frame.size()) return;
      n = frame[i]; i++;
      if (n == 8'd0 || n > 8'd128) begin
         exp_err = 1; exp_code = 2'b01; complete = 1; return;
      end
      for (int k = 0; k < int'(n); k++) begin
         if (i + 1 >= frame.size()) return;
         hi = frame[i]; lo = frame[i+1]; i += 2;
         cs = cs ^ hi ^ lo;
         if (lo[2:0] == 3'd0 || lo[2:0] > 3'd4) begin
            exp_err = 1; exp_code = 2'b11; complete = 1; return;
         end
         exp_q.push_back({8'(2 * k), hi, lo});
         exp_words = 8'(k + 1);
      end
      if (i >= frame.size()) return;
      if (frame[i] == cs) exp_done = 1;
      else begin exp_err = 1; exp_code = 2'b10; end
      complete = 1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit hold);
      int w;
      w = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (!bus.rx_ready && w < 16) begin
         @(negedge clk);
         w++;
      end
      if (!bus.rx_ready) begin
         n_checks++;
         $display("FAIL rx_ready_timeout: got rx_ready 0 for byte %0h, required 1 within 16 cycles", b);
         bus.rx_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (!hold) begin
         bus.rx_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic send_frame(input bit hold);
      bit complete;
      frame_no++;
      model_frame(complete);
      foreach (frame[i]) send_byte(frame[i], hold);
      bus.rx_valid = 1'b0;
      if (complete) begin
         chk("busy_end", busy, 0);
         chk("load_done", load_done, exp_done);
         chk("load_err", load_err, exp_err);
         chk("err_code", err_code, exp_code);
         chk("words_loaded", words_loaded, exp_words);
         chk("pending_writes", exp_q.size(), 0);
      end
      $display("frame %0d: %0d bytes, done=%0b err=%0b code=%0d words=%0d",
               frame_no, frame.size(), load_done, load_err, err_code, words_loaded);
   endtask

   task automatic check_zero();
      chk("rst_rx_ready", bus.rx_ready, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_words", words_loaded, 0);
   endtask

   initial begin
      int         c0;
      logic [7:0] cs;
      bit         dummy;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_zero();
      res = 1'b1;
      @(negedge clk);

      // Nominal two-word frame
      do_start();
      frame = '{8'hA5, 8'h02, 8'h01, 8'h21, 8'h03, 8'h42, 8'h61};
      send_frame(0);
      chk("lit_mem0", tb_mem[0], 16'h0121);
      chk("lit_mem2", tb_mem[1], 16'h0342);
      chk("addr_hold", bus.mem_addr, 8'h02);
      chk("wdata_hold", bus.mem_wdata, 16'h0342);
      chk("lit_words2", words_loaded, 8'd2);

      // Garbage before header
      do_start();
      frame = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h10, 8'h0C, 8'h1C};
      send_frame(0);
      chk("lit_garbage_mem0", tb_mem[0], 16'h100C);
      chk("lit_garbage_done", load_done, 1);

      // Bad checksum
      do_start();
      frame = '{8'hA5, 8'h01, 8'h10, 8'h0C, 8'h00};
      send_frame(0);
      chk("lit_csum_code", err_code, 2'b10);

      // Length boundaries
      do_start();
      frame = '{8'hA5, 8'h00};
      send_frame(0);
      chk("lit_len0_code", err_code, 2'b01);
      do_start();
      frame = '{8'hA5, 8'h81};
      send_frame(0);

      // Illegal op_codes 7 and 0
      do_start();
      frame = '{8'hA5, 8'h01, 8'h05, 8'h07};
      send_frame(0);
      chk("lit_op_code", err_code, 2'b11);
      do_start();
      frame = '{8'hA5, 8'h01, 8'h00, 8'h00};
      send_frame(0);

      // Largest legal frame: 128 words, last at byte address 0xFE
      do_start();
      frame.delete();
      frame.push_back(8'hA5);
      frame.push_back(8'h80);
      cs = 8'h00;
      for (int k = 0; k < 128; k++) begin
         logic [7:0] hi, lo;
         hi = 8'(k);
         lo = {hi[4:0], 3'(k % 4 + 1)};
         frame.push_back(hi);
         frame.push_back(lo);
         cs = cs ^ hi ^ lo;
      end
      frame.push_back(cs);
      send_frame(1);
      chk("lit_max_last", tb_mem[127], 16'h7FFC);
      chk("lit_max_addr", bus.mem_addr, 8'hFE);

      // Continuous rx_valid: minimum frame time 3N+3 cycles
      do_start();
      frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h7B, 8'h0B};
      c0 = cyc;
      send_frame(1);
      chk("lit_frame_cycles", cyc - c0, 9);
      chk("lit_hold_done", load_done, 1);

      // Reset after 1 of 3 words, then a fresh frame from address 0
      do_start();
      frame = '{8'hA5, 8'h03, 8'h11, 8'h21};
      model_frame(dummy);
      foreach (frame[i]) send_byte(frame[i], 0);
      chk("partial_writes", exp_q.size(), 0);
      chk("partial_busy", busy, 1);
      res = 1'b0;
      @(negedge clk);
      check_zero();
      res = 1'b1;
      @(negedge clk);
      do_start();
      frame = '{8'hA5, 8'h01, 8'h77, 8'h22, 8'h55};
      send_frame(0);
      chk("lit_after_rst_mem0", tb_mem[0], 16'h7722);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
